// File: rtl/pll_seq_pkg.sv
// Shared types and helpers for the PLL lock/reset sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        STABLE,
        RELEASE,
        RUN,
        FAIL,
        DRAIN,
        BYP_REL
    } state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for a single asynchronous level, cleared by synchronous reset.
module sync_ff2 (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_meta <= 1'b0;
            r_q    <= 1'b0;
        end else begin
            r_meta <= i_d;
            r_q    <= r_meta;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Lock supervisor for an iCE40 PLL: drives RESETB/BYPASS, retries on lock timeout,
// and releases downstream domain resets in order once lock has been stable.
module pll_reset_sequencer
    import pll_seq_pkg::*;
#(
    parameter int NUM_DOMAINS   = 4,
    parameter int RESET_HOLD    = 16,
    parameter int LOCK_TIMEOUT  = 4096,
    parameter int STABLE_CYCLES = 64,
    parameter int STAGE_GAP     = 8,
    parameter int MAX_RETRIES   = 3,
    localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bypass_req,
    input  logic                   pll_lock,
    output logic                   pll_resetb,
    output logic                   pll_bypass,
    output logic [NUM_DOMAINS-1:0] dom_rst,
    output logic                   locked,
    output logic                   fail,
    output logic [RET_W-1:0]       retries,
    output state_t                 o_dbg_state
);

    localparam int CNT_W = $clog2(max3(max3(RESET_HOLD, LOCK_TIMEOUT, STABLE_CYCLES), STAGE_GAP, 1)) + 1;
    localparam int STG_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RESET_HOLD - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    // Entering STABLE already consumed one high sample of lock_s.
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'((STABLE_CYCLES >= 2) ? STABLE_CYCLES - 2 : 0);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);
    localparam logic [STG_W-1:0] STG_LAST     = STG_W'((NUM_DOMAINS >= 2) ? NUM_DOMAINS - 2 : 0);
    localparam logic [RET_W-1:0] RET_MAX      = RET_W'(MAX_RETRIES);
    localparam logic [NUM_DOMAINS-1:0] ALL_RST = {NUM_DOMAINS{1'b1}};

    logic                   w_lock_s;
    state_t                 r_state, w_state_nx;
    logic [CNT_W-1:0]       r_cnt, w_cnt_nx, w_cnt_inc;
    logic [STG_W-1:0]       r_stage, w_stage_nx;
    logic [RET_W-1:0]       r_retries, w_retries_nx;
    logic [NUM_DOMAINS-1:0] r_dom_rst, w_dom_nx;
    logic                   r_resetb, w_resetb_nx;
    logic                   r_bypass, w_bypass_nx;
    logic                   r_locked, w_locked_nx;
    logic                   r_fail, w_fail_nx;
    logic                   r_byp_q;
    logic                   w_go_rel;
    logic                   w_lose;

    sync_ff2 u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (pll_lock),
        .o_q   (w_lock_s)
    );

    assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + CNT_W'(1);

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_stage_nx   = r_stage;
        w_retries_nx = r_retries;
        w_dom_nx     = r_dom_rst;
        w_resetb_nx  = r_resetb;
        w_bypass_nx  = r_bypass;
        w_locked_nx  = r_locked;
        w_fail_nx    = r_fail;
        w_go_rel     = 1'b0;
        w_lose       = 1'b0;

        // A change of bypass_req overrides everything; DRAIN resolves the direction itself.
        if (r_state != DRAIN && bypass_req != r_byp_q) begin
            w_state_nx  = DRAIN;
            w_dom_nx    = ALL_RST;
            w_locked_nx = 1'b0;
            w_fail_nx   = 1'b0;
            w_cnt_nx    = '0;
        end else begin
            case (r_state)
                HOLD: begin
                    w_resetb_nx = 1'b0;
                    if (r_cnt == HOLD_LAST) begin
                        w_state_nx  = WAIT_LOCK;
                        w_cnt_nx    = '0;
                        w_resetb_nx = 1'b1;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                WAIT_LOCK: begin
                    if (w_lock_s) begin
                        if (STABLE_CYCLES == 1) begin
                            w_go_rel = 1'b1;
                        end else begin
                            w_state_nx = STABLE;
                            w_cnt_nx   = '0;
                        end
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        w_cnt_nx    = '0;
                        w_resetb_nx = 1'b0;
                        if (r_retries == RET_MAX) begin
                            w_state_nx = FAIL;
                            w_fail_nx  = 1'b1;
                            w_dom_nx   = ALL_RST;
                        end else begin
                            w_state_nx   = HOLD;
                            w_retries_nx = r_retries + RET_W'(1);
                        end
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                STABLE: begin
                    if (!w_lock_s) begin
                        w_state_nx = WAIT_LOCK;
                        w_cnt_nx   = '0;
                    end else if (r_cnt == STABLE_LAST) begin
                        w_go_rel = 1'b1;
                    end else begin
                        w_cnt_nx = w_cnt_inc;
                    end
                end
                RELEASE, BYP_REL: begin
                    if (r_state == RELEASE && !w_lock_s) begin
                        w_lose = 1'b1;
                    end else if (r_dom_rst[NUM_DOMAINS-1]) begin
                        if (r_cnt == GAP_LAST) begin
                            w_dom_nx   = r_dom_rst << 1;
                            w_cnt_nx   = '0;
                            w_stage_nx = r_stage + STG_W'(1);
                            if (r_state == RELEASE && r_stage == STG_LAST) begin
                                w_state_nx  = RUN;
                                w_locked_nx = 1'b1;
                            end
                        end else begin
                            w_cnt_nx = w_cnt_inc;
                        end
                    end
                end
                RUN: begin
                    if (!w_lock_s) begin
                        w_lose = 1'b1;
                    end
                end
                FAIL: begin
                    w_resetb_nx = 1'b0;
                    w_dom_nx    = ALL_RST;
                    w_fail_nx   = 1'b1;
                end
                DRAIN: begin
                    w_cnt_nx    = '0;
                    w_stage_nx  = '0;
                    w_resetb_nx = 1'b0;
                    if (bypass_req) begin
                        w_state_nx  = BYP_REL;
                        w_bypass_nx = 1'b1;
                        w_dom_nx    = ALL_RST << 1;
                    end else begin
                        w_state_nx   = HOLD;
                        w_bypass_nx  = 1'b0;
                        w_retries_nx = '0;
                        w_dom_nx     = ALL_RST;
                    end
                end
                default: begin
                    w_state_nx = HOLD;
                    w_cnt_nx   = '0;
                end
            endcase

            if (w_go_rel) begin
                w_cnt_nx   = '0;
                w_stage_nx = '0;
                w_dom_nx   = ALL_RST << 1;
                if (NUM_DOMAINS == 1) begin
                    w_state_nx  = RUN;
                    w_locked_nx = 1'b1;
                end else begin
                    w_state_nx = RELEASE;
                end
            end

            if (w_lose) begin
                w_state_nx   = HOLD;
                w_dom_nx     = ALL_RST;
                w_locked_nx  = 1'b0;
                w_retries_nx = '0;
                w_cnt_nx     = '0;
                w_resetb_nx  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= HOLD;
            r_cnt     <= '0;
            r_stage   <= '0;
            r_retries <= '0;
            r_dom_rst <= ALL_RST;
            r_resetb  <= 1'b0;
            r_bypass  <= 1'b0;
            r_locked  <= 1'b0;
            r_fail    <= 1'b0;
            r_byp_q   <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_stage   <= w_stage_nx;
            r_retries <= w_retries_nx;
            r_dom_rst <= w_dom_nx;
            r_resetb  <= w_resetb_nx;
            r_bypass  <= w_bypass_nx;
            r_locked  <= w_locked_nx;
            r_fail    <= w_fail_nx;
            r_byp_q   <= bypass_req;
        end
    end

    assign pll_resetb  = r_resetb;
    assign pll_bypass  = r_bypass;
    assign dom_rst     = r_dom_rst;
    assign locked      = r_locked;
    assign fail        = r_fail;
    assign retries     = r_retries;
    assign o_dbg_state = r_state;

endmodule
